// File: rtl/uart_receiver.sv
// 8N1 UART receiver: one-entry holding register behind a valid/ready handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
`timescale 1ns/1ps
module uart_receiver #(
    parameter logic [15:0] WTIME = 16'h28B0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic       valid,
    output logic [7:0] data,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t      state;
    logic        rx_meta_p0;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        byte_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_err_q;

    // Even parity: data bits XOR parity bit must be zero.
    function automatic logic parity_good(input logic [7:0] d, input logic p);
        return ~(^d ^ p);
    endfunction

    assign byte_ok    = parity_good(shreg, par_bit);
    assign parity_err = parity_err_q;
`else
    assign byte_ok    = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (nrst) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            valid      <= 1'b0;
            data       <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Two-flop synchroniser; everything below looks only at rx_s.
            rx_meta_p0 <= rx;
            rx_s       <= rx_meta_p0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (valid && ready)
                valid <= 1'b0;
            if (cnt != 16'd0)
                cnt <= cnt - 16'd1;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= WTIME >> 1;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == 16'd0) begin
                        if (!rx_s) begin
                            cnt     <= WTIME;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt == 16'd0) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= WTIME;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == 16'd0) begin
                        par_bit <= rx_s;
                        cnt     <= WTIME;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt == 16'd0) begin
                        if (rx_s) begin
                            // Leave mid-stop so a back-to-back start edge is not missed.
                            state <= IDLE;
                            if (byte_ok) begin
                                if (!valid || ready) begin
                                    data  <= shreg;
                                    valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
`ifdef UART_RX_PARITY_EN
                                parity_err_q <= 1'b1;
`endif
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at WTIME=15 (16 clocks per bit).
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam logic [15:0] WT  = 16'd15;
    localparam int          BIT = 16;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int errors = 0;
    int checks = 0;
    int n_fe = 0, n_ov = 0, n_pe = 0, n_vc = 0;
    int b_fe, b_ov, b_pe, b_vc, b_q;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    uart_receiver #(.WTIME(WT)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .rx         (rx),
        .valid      (valid),
        .data       (data),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // Record handshakes and error pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (valid) n_vc++;
        if (valid && ready) got_q.push_back(data);
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (parity_err) n_pe++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop);
    endtask

    task automatic mark();
        b_fe = n_fe; b_ov = n_ov; b_pe = n_pe; b_vc = n_vc; b_q = got_q.size();
    endtask

    initial begin
        idle(3);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_fe", int'(frame_err), 0);
        chk("rst_ov", int'(overrun), 0);
        chk("rst_pe", int'(parity_err), 0);
        nrst = 1'b0;
        idle(5);

        // Single byte
        mark();
        send_frame(8'hA5, 1'b1);
        idle(20);
        chk("t1_count", got_q.size() - b_q, 1);
        chk("t1_data", int'(got_q[b_q]), 'hA5);
        chk("t1_vcyc", n_vc - b_vc, 1);
        chk("t1_fe", n_fe - b_fe, 0);
        chk("t1_ov", n_ov - b_ov, 0);

        // Back-to-back bytes, no idle gap
        mark();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(20);
        chk("t2_count", got_q.size() - b_q, 3);
        chk("t2_d0", int'(got_q[b_q]), 'h00);
        chk("t2_d1", int'(got_q[b_q+1]), 'hFF);
        chk("t2_d2", int'(got_q[b_q+2]), 'h55);
        chk("t2_err", (n_fe - b_fe) + (n_ov - b_ov), 0);

        // Short glitch is rejected, next byte received normally
        mark();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        chk("t3_noval", n_vc - b_vc, 0);
        send_frame(8'h5A, 1'b1);
        idle(20);
        chk("t3_count", got_q.size() - b_q, 1);
        chk("t3_data", int'(got_q[b_q]), 'h5A);

        // Framing error followed by a long break
        mark();
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(20);
        chk("t4_fe", n_fe - b_fe, 1);
        chk("t4_nodel", got_q.size() - b_q, 0);
        chk("t4_pe", n_pe - b_pe, 0);
        send_frame(8'h81, 1'b1);
        idle(20);
        chk("t4_count", got_q.size() - b_q, 1);
        chk("t4_data", int'(got_q[b_q]), 'h81);

        // Overrun with consumer stalled
        mark();
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(20);
        chk("t5_valid", int'(valid), 1);
        chk("t5_data", int'(data), 'h11);
        chk("t5_ov", n_ov - b_ov, 1);
        chk("t5_nohs", got_q.size() - b_q, 0);
        ready = 1'b1;
        idle(2);
        chk("t5_count", got_q.size() - b_q, 1);
        chk("t5_cons", int'(got_q[b_q]), 'h11);
        chk("t5_vdrop", int'(valid), 0);

        // Reset mid-frame discards both held and partial bytes
        mark();
        ready = 1'b0;
        send_frame(8'h42, 1'b1);
        idle(5);
        chk("t6_held", int'(valid), 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b0;
        idle(8);
        nrst = 1'b1;
        rx = 1'b1;
        idle(1);
        chk("t6_rvalid", int'(valid), 0);
        chk("t6_rdata", int'(data), 0);
        idle(2);
        nrst = 1'b0;
        ready = 1'b1;
        idle(20);
        send_frame(8'h7E, 1'b1);
        idle(20);
        chk("t6_count", got_q.size() - b_q, 1);
        chk("t6_data", int'(got_q[b_q]), 'h7E);
        chk("t6_fe", n_fe - b_fe, 0);

        // Line held low across reset release
        mark();
        rx = 1'b0;
        nrst = 1'b1;
        idle(3);
        nrst = 1'b0;
        idle(200);
        rx = 1'b1;
        idle(20);
        chk("t7_fe", n_fe - b_fe, 1);
        chk("t7_nodel", got_q.size() - b_q, 0);
        send_frame(8'h96, 1'b1);
        idle(20);
        chk("t7_count", got_q.size() - b_q, 1);
        chk("t7_data", int'(got_q[b_q]), 'h96);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit: pulse parity_err, no delivery
        mark();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h7E >> i) & 8'h01) != 8'h00);
        send_bit(1'b1);
        send_bit(1'b1);
        idle(20);
        chk("t8_pe", n_pe - b_pe, 1);
        chk("t8_noval", n_vc - b_vc, 0);
        chk("t8_fe", n_fe - b_fe, 0);
`else
        chk("pe_tied", n_pe, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
